// File: rtl/parking_tyre_classifier.sv
`default_nettype none
// ============================================================================
// Module   : parking_tyre_classifier
// Brief    : Measures debounced tyre pulses, classifies bicycle/car/oversize,
//            counts axles and emits one valid/ack record per vehicle.
// Revision : 1.0 - initial release
// ============================================================================
module parking_tyre_classifier #(
    parameter int W         = 4,
    parameter int CYCLE_MIN = 2,
    parameter int CYCLE_MAX = 4,
    parameter int CAR_MAX   = 10,
    parameter int GAP_MAX   = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       db_in,
    input  logic       veh_ack,
    output logic       veh_valid,
    output logic [1:0] veh_class,
    output logic [2:0] axle_cnt,
    output logic       busy,
    output logic       err_ovr
);

    localparam int             c_gw        = $clog2(GAP_MAX + 1);
    localparam logic [W-1:0]   c_wmax      = '1;
    localparam logic [W-1:0]   c_cyc_min   = W'(CYCLE_MIN);
    localparam logic [W-1:0]   c_cyc_max   = W'(CYCLE_MAX);
    localparam logic [W-1:0]   c_car_max   = W'(CAR_MAX);
    localparam logic [c_gw-1:0] c_gap_last = c_gw'(GAP_MAX - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_PULSE  = 2'd1,
        S_GAP    = 2'd2,
        S_REPORT = 2'd3
    } state_t;

    state_t          r_state,    w_state;
    logic [W-1:0]    r_wcnt,     w_wcnt;
    logic [c_gw-1:0] r_gcnt,     w_gcnt;
    logic            r_seen_cyc, w_seen_cyc;
    logic            r_seen_car, w_seen_car;
    logic            r_seen_big, w_seen_big;
    logic            r_valid,    w_valid;
    logic [1:0]      r_class,    w_class;
    logic [2:0]      r_axle,     w_axle;
    logic            r_busy,     w_busy;
    logic            r_err,      w_err;
    logic [2:0]      w_axle_inc;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_state    <= S_IDLE;
            r_wcnt     <= '0;
            r_gcnt     <= '0;
            r_seen_cyc <= 1'b0;
            r_seen_car <= 1'b0;
            r_seen_big <= 1'b0;
            r_valid    <= 1'b0;
            r_class    <= 2'b00;
            r_axle     <= 3'd0;
            r_busy     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_wcnt     <= w_wcnt;
            r_gcnt     <= w_gcnt;
            r_seen_cyc <= w_seen_cyc;
            r_seen_car <= w_seen_car;
            r_seen_big <= w_seen_big;
            r_valid    <= w_valid;
            r_class    <= w_class;
            r_axle     <= w_axle;
            r_busy     <= w_busy;
            r_err      <= w_err;
        end
    end

    always_comb begin
        w_state    = r_state;
        w_wcnt     = r_wcnt;
        w_gcnt     = r_gcnt;
        w_seen_cyc = r_seen_cyc;
        w_seen_car = r_seen_car;
        w_seen_big = r_seen_big;
        w_valid    = r_valid;
        w_class    = r_class;
        w_axle     = r_axle;
        w_err      = r_err;
        w_axle_inc = (r_axle == 3'd7) ? r_axle : r_axle + 3'd1;

        case (r_state)
            S_IDLE: begin
                if (db_in) begin
                    w_state = S_PULSE;
                    w_wcnt  = {{(W-1){1'b0}}, 1'b1};
                end
            end
            S_PULSE: begin
                if (db_in) begin
                    w_wcnt = (r_wcnt == c_wmax) ? r_wcnt : r_wcnt + 1'b1;
                end else begin
                    // The falling sample is the first low of the gap.
                    w_gcnt = {{(c_gw-1){1'b0}}, 1'b1};
                    if (r_wcnt < c_cyc_min) begin
                        w_state = (r_axle != 3'd0) ? S_GAP : S_IDLE;
                    end else begin
                        w_state = S_GAP;
                        w_axle  = w_axle_inc;
                        if (r_wcnt <= c_cyc_max)
                            w_seen_cyc = 1'b1;
                        else if (r_wcnt <= c_car_max)
                            w_seen_car = 1'b1;
                        else
                            w_seen_big = 1'b1;
                    end
                end
            end
            S_GAP: begin
                if (db_in) begin
                    w_state = S_PULSE;
                    w_wcnt  = {{(W-1){1'b0}}, 1'b1};
                end else if (r_gcnt == c_gap_last) begin
                    w_state = S_REPORT;
                    w_valid = 1'b1;
                    if (r_seen_big || (r_seen_cyc && r_seen_car))
                        w_class = 2'b11;
                    else if (r_seen_cyc)
                        w_class = 2'b01;
                    else
                        w_class = 2'b10;
                end else begin
                    w_gcnt = r_gcnt + 1'b1;
                end
            end
            S_REPORT: begin
                if (veh_ack) begin
                    w_valid    = 1'b0;
                    w_class    = 2'b00;
                    w_axle     = 3'd0;
                    w_seen_cyc = 1'b0;
                    w_seen_car = 1'b0;
                    w_seen_big = 1'b0;
                    if (db_in) begin
                        w_state = S_PULSE;
                        w_wcnt  = {{(W-1){1'b0}}, 1'b1};
                    end else begin
                        w_state = S_IDLE;
                    end
                end else if (db_in) begin
                    // Tyre activity while the record is still pending is lost.
                    w_err = 1'b1;
                end
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase

        w_busy = (w_state != S_IDLE);
    end

    assign veh_valid = r_valid;
    assign veh_class = r_class;
    assign axle_cnt  = r_axle;
    assign busy      = r_busy;
    assign err_ovr   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_parking_tyre_classifier.sv
`default_nettype none
// ============================================================================
// Module   : tb_parking_tyre_classifier
// Brief    : Directed self-checking bench for parking_tyre_classifier.
// Revision : 1.0 - initial release
// ============================================================================
module tb_parking_tyre_classifier;

    logic       clk;
    logic       rst_n;
    logic       db_in;
    logic       veh_ack;
    logic       veh_valid;
    logic [1:0] veh_class;
    logic [2:0] axle_cnt;
    logic       busy;
    logic       err_ovr;

    int checks;
    int errors;

    parking_tyre_classifier dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .db_in     (db_in),
        .veh_ack   (veh_ack),
        .veh_valid (veh_valid),
        .veh_class (veh_class),
        .axle_cnt  (axle_cnt),
        .busy      (busy),
        .err_ovr   (err_ovr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One sample: drive inputs, let the edge take them, settle 1 time unit.
    task automatic cyc(input logic d, input logic a);
        db_in   = d;
        veh_ack = a;
        @(posedge clk);
        #1;
    endtask

    task automatic hi(input int n);
        repeat (n) cyc(1'b1, 1'b0);
    endtask

    task automatic lo(input int n);
        repeat (n) cyc(1'b0, 1'b0);
    endtask

    task automatic chk_rec(input string tag, input int cls, input int axl);
        chk({tag, "_valid"}, int'(veh_valid), 1);
        chk({tag, "_class"}, int'(veh_class), cls);
        chk({tag, "_axle"},  int'(axle_cnt),  axl);
    endtask

    task automatic ack_idle(input string tag);
        cyc(1'b0, 1'b1);
        chk({tag, "_ack_valid"}, int'(veh_valid), 0);
        chk({tag, "_ack_busy"},  int'(busy),      0);
    endtask

    int widths  [5] = '{2, 4, 5, 10, 11};
    int wclass  [5] = '{1, 1, 2, 2, 3};

    initial begin
        checks  = 0;
        errors  = 0;
        rst_n   = 1'b1;
        db_in   = 1'b0;
        veh_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", int'(veh_valid), 0);
        chk("rst_class", int'(veh_class), 0);
        chk("rst_axle",  int'(axle_cnt),  0);
        chk("rst_busy",  int'(busy),      0);
        chk("rst_err",   int'(err_ovr),   0);
        rst_n = 1'b0;
        lo(2);
        chk("idle_busy", int'(busy), 0);

        // Single bicycle: 3 high, 5 low, 3 high, then lows.
        hi(3);
        chk("bike_busy", int'(busy), 1);
        lo(1);
        chk("bike_axle1", int'(axle_cnt), 1);
        lo(4);
        hi(3);
        lo(7);
        chk("bike_early", int'(veh_valid), 0);
        lo(1);
        chk_rec("bike", 1, 2);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        chk_rec("bike_hold", 1, 2);
        ack_idle("bike");
        chk("bike_ack_axle", int'(axle_cnt), 0);

        // Car with a 1-cycle glitch in the gap; the gap count restarts.
        hi(7);
        lo(3);
        hi(1);
        lo(7);
        chk("glitch_restart", int'(veh_valid), 0);
        lo(1);
        chk_rec("car1", 2, 1);
        ack_idle("car1");
        hi(7);
        lo(3);
        hi(1);
        lo(3);
        hi(7);
        lo(8);
        chk_rec("car2", 2, 2);
        ack_idle("car2");

        // Mixed and oversize.
        hi(3);
        lo(2);
        hi(8);
        lo(8);
        chk_rec("mixed", 3, 2);
        ack_idle("mixed");
        hi(20);
        lo(8);
        chk_rec("big", 3, 1);
        ack_idle("big");

        // Lone glitch never makes a record.
        hi(1);
        lo(1);
        chk("glitch_busy", int'(busy), 0);
        lo(8);
        chk("glitch_norec", int'(veh_valid), 0);

        // Width boundaries.
        for (int i = 0; i < 5; i++) begin
            hi(widths[i]);
            lo(8);
            chk_rec($sformatf("w%0d", widths[i]), wclass[i], 1);
            ack_idle($sformatf("w%0d", widths[i]));
        end

        // Axle count saturation.
        repeat (9) begin
            hi(2);
            lo(2);
        end
        lo(6);
        chk_rec("sat", 1, 7);
        ack_idle("sat");

        // Overrun, then ack on a high sample.
        hi(3);
        lo(8);
        chk_rec("ovr_pre", 1, 1);
        chk("ovr_pre_err", int'(err_ovr), 0);
        cyc(1'b1, 1'b0);
        chk("ovr_err", int'(err_ovr), 1);
        chk_rec("ovr_hold", 1, 1);
        cyc(1'b1, 1'b0);
        chk_rec("ovr_hold2", 1, 1);
        cyc(1'b1, 1'b1);
        chk("ovr_ack_valid", int'(veh_valid), 0);
        chk("ovr_ack_busy",  int'(busy),      1);
        hi(4);
        lo(8);
        chk_rec("partial", 2, 1);
        chk("partial_err", int'(err_ovr), 1);
        ack_idle("partial");
        chk("err_sticky", int'(err_ovr), 1);

        // Asynchronous reset in the middle of a pulse.
        hi(3);
        #2;
        rst_n = 1'b1;
        #1;
        chk("arst_busy",  int'(busy),      0);
        chk("arst_err",   int'(err_ovr),   0);
        chk("arst_valid", int'(veh_valid), 0);
        chk("arst_axle",  int'(axle_cnt),  0);
        db_in = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        lo(10);
        chk("arst_norec", int'(veh_valid), 0);
        chk("arst_idle",  int'(busy),      0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/parking_tyre_classifier.md
# parking_tyre_classifier

Consumes the debounced tyre-sensor level from the parking-lane debouncer and turns it into one record per vehicle. It measures each tyre pulse width and classifies it as bicycle or car. It counts axles, detects the end of a vehicle from an idle gap, and delivers a valid/ack record to the parking controller.

## Interface
- `W`, 4: width-counter bits; the counter saturates at 2^W-1.
- `CYCLE_MIN`, 2: minimum high width (cycles) for a valid tyre. Narrower pulses are glitches.
- `CYCLE_MAX`, 4: maximum high width for a bicycle tyre.
- `CAR_MAX`, 10: maximum high width for a car tyre. The car range is CYCLE_MAX+1..CAR_MAX.
- `GAP_MAX`, 8: consecutive low samples that end a vehicle. Must be ≥2.
- `clk`  in  1  clock; all logic on posedge.
- `rst_n`  in  1  reset, asynchronous, active-high. Despite the name, 1 = reset.
- `db_in`  in  1  debounced tyre level; 1 = tyre on sensor.
- `veh_ack`  in  1  controller accepts the current record.
- `veh_valid`  out  1  record available; held until acknowledged.
- `veh_class`  out  2  00 none, 01 bicycle, 10 car, 11 mixed/oversize.
- `axle_cnt`  out  3  valid tyre pulses in the vehicle; saturates at 7.
- `busy`  out  1  FSM not in IDLE.
- `err_ovr`  out  1  sticky: sensor activity was lost while a record was pending.

## Operation
- Internal state: FSM {IDLE, PULSE, GAP, REPORT}, `wcnt[W-1:0]`, `gcnt` (wide enough for GAP_MAX), and flags `seen_cyc`, `seen_car`, `seen_big`.
- All outputs are registered.
- **IDLE**
  - db_in=1 → PULSE, wcnt=1.
  - Otherwise stay in IDLE.
- **PULSE**
  - db_in=1 → wcnt=min(wcnt+1, 2^W-1).
  - db_in=0 → classify wcnt:
    - wcnt<CYCLE_MIN: glitch. axle_cnt and flags are unchanged. Go to GAP with gcnt=1 if axle_cnt>0, else go to IDLE.
    - CYCLE_MIN..CYCLE_MAX: set seen_cyc, increment axle_cnt (saturating), go to GAP with gcnt=1.
    - CYCLE_MAX+1..CAR_MAX: set seen_car, increment axle_cnt, go to GAP with gcnt=1.
    - >CAR_MAX (includes a saturated counter): set seen_big, increment axle_cnt, go to GAP with gcnt=1.
- **GAP**
  - db_in=1 → PULSE, wcnt=1.
  - db_in=0 and gcnt==GAP_MAX-1 → REPORT. This sample is the GAP_MAX-th consecutive low.
  - Otherwise gcnt+1.
- **On entry to REPORT**
  - veh_valid=1.
  - veh_class = 11 if seen_big, or if seen_cyc and seen_car are both set; else 01 if seen_cyc; else 10.
  - axle_cnt is frozen.
- **REPORT**
  - veh_ack=1 → clear veh_valid, veh_class, axle_cnt, and all flags.
    - If db_in=1 in the same sample, go to PULSE with wcnt=1.
    - Otherwise go to IDLE.
  - veh_ack=0 and db_in=1 → set err_ovr and stay in REPORT. The pulse is not measured.
- veh_ack is ignored in every state except REPORT.
- err_ovr clears only on reset.
- busy = (state != IDLE), registered alongside the state.

## Timing
- **Reset** (async assert, sync release): state=IDLE, all counters and flags 0, veh_valid=0, veh_class=00, axle_cnt=0, busy=0, err_ovr=0.
- **Reset mid-operation:** a partial vehicle is discarded and no record is produced.
- **Width:** a pulse high for N consecutive samples gives wcnt=N at the falling sample.
- **Record latency:** veh_valid rises at the edge that samples the GAP_MAX-th consecutive low after the last tyre falls.
- **Handshake:** veh_valid, veh_class and axle_cnt stay stable until the edge that samples veh_ack=1. veh_valid is 0 from that edge onward.
- **Minimum spacing:** back-to-back records are separated by at least one cycle with veh_valid=0.
- **Single-vehicle reach:** a glitch-only burst never reaches REPORT.

## Test plan
- **Single bicycle:** reset, then pulses of 3 high, 5 low, 3 high, then low with GAP_MAX=8 → veh_valid rises at the 8th low after the second pulse; veh_class=01, axle_cnt=2; ack → veh_valid=0 next edge, FSM returns to IDLE.
- **Car with glitch:** pulses 7 high, 1-cycle glitch inside the gap, 7 high → glitch not counted; veh_class=10, axle_cnt=2. The gap count restarts after the glitch.
- **Mixed and oversize:** widths 3 then 8 → class 11. A 20-cycle pulse (wcnt saturates at 15) → class 11, axle_cnt=1.
- **Boundaries:**
  - Width 1 alone → no record, busy returns to 0.
  - Width 2 → 01; width 4 → 01; width 5 → 10; width 10 → 10; width 11 → 11.
  - 9 pulses → axle_cnt saturates at 7.
- **Overrun and same-cycle ack:** with a record pending and no ack, raise db_in → err_ovr=1 and the record is unchanged. Ack while db_in=1 → FSM goes to PULSE with wcnt=1, and the next record counts that partial pulse.
- **Async reset mid-pulse:** assert rst_n between clock edges during PULSE → all outputs are 0 immediately, and no record appears after release.
